// File: rtl/uart_byte_tx.sv
// Serial byte transmitter: start, 8 data bits LSB first, optional odd/even parity, stop; launched by a send_en rising edge.
// Start bit appears 2 clocks after send_en is first sampled high; requests arriving while busy are dropped, never queued.
module uart_byte_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int PARITY   = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       send_en,
    input  logic [7:0] send_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam int NBITS   = PAR_EN ? 11 : 10;
    localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BPS_CNT - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(NBITS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic          d0;
    logic          d1;
    logic          armed;
    logic [7:0]    data_buf;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic          start;
    logic          par_bit;
    logic [3:0]    next_idx;
    logic [10:0]   frame;

    // armed stays low after reset until send_en has been seen low, so a level
    // already high at reset release cannot masquerade as a rising edge.
    assign start    = d0 & ~d1 & armed;
    assign par_bit  = (PARITY == 1) ? ~^data_buf : ^data_buf;
    assign next_idx = bit_idx + 4'd1;
    assign frame    = {1'b1, (PAR_EN ? par_bit : 1'b1), data_buf, 1'b0};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            d0       <= 1'b0;
            d1       <= 1'b0;
            armed    <= 1'b0;
            data_buf <= 8'h00;
            baud_cnt <= '0;
            bit_idx  <= 4'd0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            d0      <= send_en;
            d1      <= d0;
            armed   <= armed | ~send_en;
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_buf <= send_data;
                        state    <= SEND;
                        tx_busy  <= 1'b1;
                        uart_txd <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= 4'd0;
                    end
                end
                SEND: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state    <= IDLE;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                            uart_txd <= 1'b1;
                            bit_idx  <= 4'd0;
                        end else begin
                            bit_idx  <= next_idx;
                            uart_txd <= frame[next_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: default, odd-parity and even-parity instances at 50 MHz / 115200.
module tb_uart_byte_tx;
    localparam int BPS = 434;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       send_en   = 1'b0;
    logic       send_en_p = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       busy0, done0, txd0;
    logic       busy1, done1, txd1;
    logic       busy2, done2, txd2;
    logic       mon_busy, mon_txd;
    int         mon_sel = 0;
    int         checks = 0;
    int         failures = 0;
    int         done_n0 = 0;
    int         done_n1 = 0;
    int         done_n2 = 0;

    always #5 clk = ~clk;

    uart_byte_tx dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .send_en(send_en), .send_data(send_data),
        .tx_busy(busy0), .tx_done(done0), .uart_txd(txd0)
    );
    uart_byte_tx #(.PARITY(1)) dut_odd (
        .sys_clk(clk), .sys_rst_n(rst_n), .send_en(send_en_p), .send_data(send_data),
        .tx_busy(busy1), .tx_done(done1), .uart_txd(txd1)
    );
    uart_byte_tx #(.PARITY(2)) dut_even (
        .sys_clk(clk), .sys_rst_n(rst_n), .send_en(send_en_p), .send_data(send_data),
        .tx_busy(busy2), .tx_done(done2), .uart_txd(txd2)
    );

    always_comb begin
        mon_busy = busy0;
        mon_txd  = txd0;
        if (mon_sel == 1) begin
            mon_busy = busy1;
            mon_txd  = txd1;
        end else if (mon_sel == 2) begin
            mon_busy = busy2;
            mon_txd  = txd2;
        end
    end

    always @(negedge clk) begin
        if (done0) done_n0++;
        if (done1) done_n1++;
        if (done2) done_n2++;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Raises the selected send_en at a falling edge and counts falling edges until busy.
    task automatic kick(input bit par, input logic [7:0] d, output int lat);
        send_data = d;
        if (par) send_en_p = 1'b1;
        else     send_en   = 1'b1;
        lat = 0;
        while (!mon_busy && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Records the frame of the monitored instance; bits[i] is line bit i sampled mid-bit.
    task automatic capture(output logic [10:0] bits, output int len, output int glitches, output bit got);
        logic prev;
        bits = '0; len = 0; glitches = 0; got = 1'b0;
        for (int i = 0; i < 40 && !mon_busy; i++) @(negedge clk);
        if (!mon_busy) return;
        got  = 1'b1;
        prev = mon_txd;
        while (mon_busy && len < 6000) begin
            if ((len % BPS) == BPS / 2 && (len / BPS) < 11) bits[len / BPS] = mon_txd;
            if ((len % BPS) != 0 && mon_txd !== prev) glitches++;
            prev = mon_txd;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (txd0 !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", txd0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done0); end
        checks++; if (txd2 !== 1'b1) begin failures++; $display("FAIL reset_txd_even: got %b want 1", txd2); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [10:0] bits; int len, gl, lat, dn; bit got;
        mon_sel = 0;
        dn = done_n0;
        kick(1'b0, 8'hAF, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency: got %0d want 2", lat); end
        checks++; if (mon_txd !== 1'b0) begin failures++; $display("FAIL basic_start_bit: got %b want 0", mon_txd); end
        fork
            begin @(negedge clk); send_en = 1'b0; end
        join_none
        capture(bits, len, gl, got);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL basic_frame_seen: got %b want 1", got); end
        checks++; if (bits !== 11'b01101011110) begin failures++; $display("FAIL basic_bits: got %b want %b", bits, 11'b01101011110); end
        checks++; if (len !== 4340) begin failures++; $display("FAIL basic_busy_len: got %0d want 4340", len); end
        checks++; if (gl !== 0) begin failures++; $display("FAIL basic_mid_bit_edges: got %0d want 0", gl); end
        repeat (3) @(negedge clk);
        checks++; if (done_n0 - dn !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_n0 - dn); end
        checks++; if (mon_txd !== 1'b1) begin failures++; $display("FAIL basic_idle_high: got %b want 1", mon_txd); end
    endtask

    task automatic test_parity;
        logic [10:0] bits; int len, gl, lat; bit got;
        mon_sel = 2;
        kick(1'b1, 8'h55, lat);
        capture(bits, len, gl, got);
        checks++; if (bits !== 11'b10010101010) begin failures++; $display("FAIL even_bits: got %b want %b", bits, 11'b10010101010); end
        checks++; if (len !== 4774) begin failures++; $display("FAIL even_busy_len: got %0d want 4774", len); end
        checks++; if (gl !== 0) begin failures++; $display("FAIL even_mid_bit_edges: got %0d want 0", gl); end
        send_en_p = 1'b0;
        repeat (5) @(negedge clk);
        mon_sel = 1;
        kick(1'b1, 8'h55, lat);
        capture(bits, len, gl, got);
        checks++; if (bits !== 11'b11010101010) begin failures++; $display("FAIL odd_bits: got %b want %b", bits, 11'b11010101010); end
        checks++; if (len !== 4774) begin failures++; $display("FAIL odd_busy_len: got %0d want 4774", len); end
        send_en_p = 1'b0;
        mon_sel = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_ignore;
        logic [10:0] bits; int len, gl, lat, dn, seen; bit got;
        mon_sel = 0;
        dn = done_n0;
        kick(1'b0, 8'hAF, lat);
        fork
            begin
                repeat (4 * BPS + 100) @(negedge clk);
                send_en = 1'b0;
                repeat (4) @(negedge clk);
                send_en = 1'b1;
            end
        join_none
        capture(bits, len, gl, got);
        checks++; if (bits !== 11'b01101011110) begin failures++; $display("FAIL ignore_bits: got %b want %b", bits, 11'b01101011110); end
        checks++; if (len !== 4340) begin failures++; $display("FAIL ignore_busy_len: got %0d want 4340", len); end
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy0 || !txd0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL ignore_no_retrigger: got %0d busy cycles want 0", seen); end
        checks++; if (done_n0 - dn !== 1) begin failures++; $display("FAIL ignore_done_pulses: got %0d want 1", done_n0 - dn); end
        send_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latch;
        logic [10:0] bits; int len, gl, lat; bit got;
        kick(1'b0, 8'hAF, lat);
        send_data = 8'h00;
        send_en   = 1'b0;
        capture(bits, len, gl, got);
        checks++; if (bits !== 11'b01101011110) begin failures++; $display("FAIL latch_bits: got %b want %b", bits, 11'b01101011110); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits; int len, gl, lat, seen; bit got;
        kick(1'b0, 8'hA7, lat);
        repeat (4 * BPS + 200) @(negedge clk);
        checks++; if (txd0 !== 1'b0) begin failures++; $display("FAIL midrst_data_bit3: got %b want 0", txd0); end
        rst_n = 1'b0;
        #1;
        checks++; if (txd0 !== 1'b1) begin failures++; $display("FAIL midrst_txd: got %b want 1", txd0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy0); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy0 || !txd0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_level_no_start: got %0d active cycles want 0", seen); end
        send_en = 1'b0;
        repeat (3) @(negedge clk);
        kick(1'b0, 8'h3C, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL midrst_restart_latency: got %0d want 2", lat); end
        send_en = 1'b0;
        capture(bits, len, gl, got);
        checks++; if (bits !== 11'b01001111000) begin failures++; $display("FAIL midrst_restart_bits: got %b want %b", bits, 11'b01001111000); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits; int len, gl, lat, gap; bit got;
        kick(1'b0, 8'hAF, lat);
        fork
            begin repeat (3) @(negedge clk); send_en = 1'b0; end
        join_none
        capture(bits, len, gl, got);
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL b2b_done_at_fall: got %b want 1", done0); end
        gap = 0;
        while (!busy0 && gap < 20) begin
            gap++;
            if (gap == 2) begin
                send_data = 8'h5A;
                send_en   = 1'b1;
            end
            @(negedge clk);
        end
        checks++; if (gap !== 3) begin failures++; $display("FAIL b2b_gap: got %0d idle cycles want 3", gap); end
        capture(bits, len, gl, got);
        checks++; if (bits !== 11'b01010110100) begin failures++; $display("FAIL b2b_bits: got %b want %b", bits, 11'b01010110100); end
        checks++; if (len !== 4340) begin failures++; $display("FAIL b2b_busy_len: got %0d want 4340", len); end
        send_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_ignore();
        test_latch();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
